// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the program-counter fetch stage
//
// Purpose: next-PC select encodings, fetch FSM state type and the
// instruction width shared by pc_fetch_ctrl and next_pc_calc.
// Ports: none (package).
package cpu_pkg;

  localparam int INST_W = 32;

  // PCSrc encodings
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC target and legality check
//
// Purpose: computes PC+4, the selected next-PC target and whether that
// target lies outside the instruction store or is not word aligned.
// Ports:
//   IAddr     in  32  current PC
//   PCSrc     in  2   next-PC select (PC_SEQ / PC_BR / PC_J / PC_JR)
//   immediate in  16  branch offset in words, sign-extended
//   JumpAddr  in  26  jump target field
//   RegAddr   in  32  jump-register target
//   PC4       out 32  IAddr + 4
//   target    out 32  selected next PC
//   illegal   out 1   target misaligned or beyond MEM_BYTES-4
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int MEM_BYTES = 64
) (
  input  logic [INST_W-1:0] IAddr,
  input  logic [1:0]        PCSrc,
  input  logic [15:0]       immediate,
  input  logic [25:0]       JumpAddr,
  input  logic [INST_W-1:0] RegAddr,
  output logic [INST_W-1:0] PC4,
  output logic [INST_W-1:0] target,
  output logic              illegal
);

  localparam logic [INST_W-1:0] MAX_PC = INST_W'(MEM_BYTES - 4);

  logic [INST_W-1:0] br_off;

  assign PC4 = IAddr + 32'd4;

  // Word offset sign-extended and scaled to bytes.
  assign br_off = {{14{immediate[15]}}, immediate, 2'b00};

  always_comb begin
    target = PC4;
    case (PCSrc)
      PC_SEQ:  target = PC4;
      PC_BR:   target = PC4 + br_off;
      PC_J:    target = {PC4[31:28], JumpAddr, 2'b00};
      PC_JR:   target = RegAddr;
      default: target = PC4;
    endcase
  end

  assign illegal = (target[1:0] != 2'b00) || (target > MAX_PC);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter, RUN/HALT/FAULT FSM and retire counter
//
// Purpose: holds the PC driving instruction memory, advances it to the
// selected target, stops on halt or on an illegal target, and counts
// retired instructions (saturating).
// Ports:
//   CLK       in  1      system clock, rising edge
//   Reset     in  1      asynchronous active-high reset
//   PCWre     in  1      1 = PC may advance this cycle
//   PCSrc     in  2      next-PC select
//   immediate in  16     branch offset in words
//   JumpAddr  in  26     jump target field
//   RegAddr   in  32     jump-register target
//   Halt      in  1      halt instruction at current PC
//   IAddr     out 32     current PC
//   PC4       out 32     IAddr + 4
//   Halted    out 1      state == HALT
//   Fault     out 1      state == FAULT
//   InstCount out CNT_W  retired instructions since reset
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 64,
  parameter int          CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [15:0]      immediate,
  input  logic [25:0]      JumpAddr,
  input  logic [31:0]      RegAddr,
  input  logic             Halt,
  output logic [31:0]      IAddr,
  output logic [31:0]      PC4,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] InstCount
);

  state_t            state;
  logic [31:0]       target;
  logic              illegal;
  logic [CNT_W-1:0]  cnt_inc;

  next_pc_calc #(
    .MEM_BYTES (MEM_BYTES)
  ) u_next_pc (
    .IAddr     (IAddr),
    .PCSrc     (PCSrc),
    .immediate (immediate),
    .JumpAddr  (JumpAddr),
    .RegAddr   (RegAddr),
    .PC4       (PC4),
    .target    (target),
    .illegal   (illegal)
  );

  // Saturating increment: sticks at all-ones.
  assign cnt_inc = (InstCount == {CNT_W{1'b1}}) ? InstCount
                                                : InstCount + CNT_W'(1);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      IAddr     <= RESET_PC;
      state     <= RUN;
      Halted    <= 1'b0;
      Fault     <= 1'b0;
      InstCount <= '0;
    end else begin
      case (state)
        RUN: begin
          if (Halt) begin
            // Halt retires and wins over any target, legal or not.
            state     <= HALT;
            Halted    <= 1'b1;
            InstCount <= cnt_inc;
          end else if (PCWre) begin
            if (!illegal) begin
              IAddr     <= target;
              InstCount <= cnt_inc;
            end else begin
              // PC stays on the faulting instruction for debug.
              state <= FAULT;
              Fault <= 1'b1;
            end
          end
        end
        HALT, FAULT: begin
          // Terminal until Reset.
        end
        default: begin
          state <= FAULT;
          Fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [15:0] immediate;
  logic [25:0] JumpAddr;
  logic [31:0] RegAddr;
  logic        Halt;
  logic [31:0] IAddr;
  logic [31:0] PC4;
  logic        Halted;
  logic        Fault;
  logic [3:0]  InstCount;

  int checks = 0;
  int failures = 0;

  pc_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (64),
    .CNT_W     (4)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .immediate (immediate),
    .JumpAddr  (JumpAddr),
    .RegAddr   (RegAddr),
    .Halt      (Halt),
    .IAddr     (IAddr),
    .PC4       (PC4),
    .Halted    (Halted),
    .Fault     (Fault),
    .InstCount (InstCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    PCWre = 1'b0; PCSrc = 2'b00; Halt = 1'b0;
    immediate = 16'h0; JumpAddr = 26'h0; RegAddr = 32'h0;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                             input logic h, input logic f);
    check({tag, "_iaddr"}, IAddr, pc);
    check({tag, "_cnt"}, 32'(InstCount), cnt);
    check({tag, "_halted"}, 32'(Halted), 32'(h));
    check({tag, "_fault"}, 32'(Fault), 32'(f));
  endtask

  initial begin
    // Reset state
    do_reset();
    check_state("reset", 32'h0, 0, 1'b0, 1'b0);
    check("reset_pc4", PC4, 32'h4);

    // 1: sequential stepping
    PCWre = 1'b1; PCSrc = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("seq%0d_iaddr", i), IAddr, 32'(4 * i));
    end
    check("seq_cnt", 32'(InstCount), 5);
    check("seq_pc4", PC4, 32'd24);

    // 2: backward branch then stall
    do_reset();
    PCWre = 1'b1; PCSrc = 2'b00;
    step(); step();
    check("pre_br_iaddr", IAddr, 32'h8);
    PCSrc = 2'b01; immediate = 16'hFFFE;
    step();
    check_state("br", 32'h4, 3, 1'b0, 1'b0);
    PCWre = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_state("stall", 32'h4, 3, 1'b0, 1'b0);

    // 3: jump, then out-of-range register jump faults
    PCWre = 1'b1; PCSrc = 2'b10; JumpAddr = 26'h00000A;
    step();
    check_state("jump", 32'h28, 4, 1'b0, 1'b0);
    PCSrc = 2'b11; RegAddr = 32'h40;
    step();
    check_state("jr_range", 32'h28, 4, 1'b0, 1'b1);
    PCSrc = 2'b00; Halt = 1'b1;
    step(); step();
    check_state("fault_frozen", 32'h28, 4, 1'b0, 1'b1);

    // 4: misaligned register jump
    do_reset();
    PCWre = 1'b1; PCSrc = 2'b00;
    step();
    PCSrc = 2'b11; RegAddr = 32'h6;
    step();
    check_state("jr_misalign", 32'h4, 1, 1'b0, 1'b1);

    // Boundary: last legal word, then one past it
    do_reset();
    PCWre = 1'b1; PCSrc = 2'b11; RegAddr = 32'h3C;
    step();
    check_state("jr_last", 32'h3C, 1, 1'b0, 1'b0);
    PCSrc = 2'b00;
    step();
    check_state("seq_past_end", 32'h3C, 1, 1'b0, 1'b1);

    // 5: halt wins over an illegal target
    do_reset();
    PCWre = 1'b1; PCSrc = 2'b00;
    step(); step(); step();
    check("pre_halt_iaddr", IAddr, 32'hC);
    Halt = 1'b1; PCSrc = 2'b11; RegAddr = 32'h40;
    step();
    check_state("halt", 32'hC, 4, 1'b1, 1'b0);
    Halt = 1'b0; PCSrc = 2'b00;
    for (int i = 0; i < 3; i++) begin
      PCWre = 1'b1; step();
      PCWre = 1'b0; step();
    end
    check_state("halt_frozen", 32'hC, 4, 1'b1, 1'b0);

    // 6: asynchronous reset mid-cycle while halted
    @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    check_state("async_rst", 32'h0, 0, 1'b0, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    PCWre = 1'b1; PCSrc = 2'b00;
    step();
    check_state("resume", 32'h4, 1, 1'b0, 1'b0);

    // Counter saturation (4-bit counter): loop on address 0
    do_reset();
    PCWre = 1'b1; PCSrc = 2'b11; RegAddr = 32'h0;
    for (int i = 0; i < 20; i++) step();
    check_state("sat", 32'h0, 15, 1'b0, 1'b0);
    Halt = 1'b1;
    step();
    check_state("sat_halt", 32'h0, 15, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
